// File: rtl/disp_reg_arbiter.sv
// Round-robin arbiter/sequencer that funnels two requesters' register commands
// onto the shared dispatcher configuration port, with ack timeout and error count.
//
// state | meaning
// IDLE  | port quiet; grants a pending slot (round robin when both pending)
// ISSUE | one transaction held on the port until ack or timeout
module disp_reg_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERROR_DATA     = 32'hDEAD_BEEF
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iReq0Valid,
  input  logic        iReq0Write,
  input  logic [31:0] iReq0Address,
  input  logic [31:0] iReq0WriteData,
  output logic        oReq0Ready,
  output logic        oReq0Done,
  output logic        oReq0Error,
  output logic [31:0] oReq0ReadData,
  input  logic        iReq1Valid,
  input  logic        iReq1Write,
  input  logic [31:0] iReq1Address,
  input  logic [31:0] iReq1WriteData,
  output logic        oReq1Ready,
  output logic        oReq1Done,
  output logic        oReq1Error,
  output logic [31:0] oReq1ReadData,
  output logic [31:0] oWriteAddress,
  output logic [31:0] oWriteData,
  output logic        oWriteValid,
  input  logic        iWriteAck,
  output logic [31:0] oReadAddress,
  output logic        oReadValid,
  input  logic [31:0] iReadData,
  input  logic        iReadAck,
  output logic        oBusy,
  output logic [7:0]  oErrorCount
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } stateT;

  localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT_CYCLES - 1);

  stateT       state;
  stateT       stateNext;

  logic [1:0]  reqValid;
  logic [1:0]  reqWrite;
  logic [31:0] reqAddress [2];
  logic [31:0] reqData    [2];

  logic [1:0]  pending;
  logic [1:0]  slotWrite;
  logic [31:0] slotAddress [2];
  logic [31:0] slotData    [2];

  logic        grantNow;
  logic        grantSel;
  logic        complete;
  logic        timedOut;
  logic        ackSeen;

  logic        curGrant;
  logic        curWrite;
  logic        lastGrant;
  logic [15:0] timer;

  logic [1:0]  doneReg;
  logic [1:0]  errorReg;
  logic [31:0] readDataReg [2];

  assign reqValid      = {iReq1Valid, iReq0Valid};
  assign reqWrite      = {iReq1Write, iReq0Write};
  assign reqAddress[0] = iReq0Address;
  assign reqAddress[1] = iReq1Address;
  assign reqData[0]    = iReq0WriteData;
  assign reqData[1]    = iReq1WriteData;

  always_comb begin
    stateNext = state;
    grantNow  = 1'b0;
    grantSel  = 1'b0;
    complete  = 1'b0;
    timedOut  = 1'b0;
    // Only the ack matching the issued transaction type is honoured.
    ackSeen   = curWrite ? iWriteAck : iReadAck;
    case (state)
      IDLE: begin
        if (|pending) begin
          grantNow  = 1'b1;
          grantSel  = (&pending) ? ~lastGrant : pending[1];
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        if (ackSeen) begin
          complete  = 1'b1;
          stateNext = IDLE;
        end else if (timer == '0) begin
          complete  = 1'b1;
          timedOut  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      pending        <= '0;
      slotWrite      <= '0;
      slotAddress[0] <= '0;
      slotAddress[1] <= '0;
      slotData[0]    <= '0;
      slotData[1]    <= '0;
      curGrant       <= 1'b0;
      curWrite       <= 1'b0;
      lastGrant      <= 1'b1;
      timer          <= '0;
      oWriteAddress  <= '0;
      oWriteData     <= '0;
      oWriteValid    <= 1'b0;
      oReadAddress   <= '0;
      oReadValid     <= 1'b0;
      doneReg        <= '0;
      errorReg       <= '0;
      readDataReg[0] <= '0;
      readDataReg[1] <= '0;
      oErrorCount    <= '0;
    end else begin
      doneReg  <= '0;
      errorReg <= '0;

      for (int n = 0; n < 2; n++) begin
        if (reqValid[n] && !pending[n]) begin
          pending[n]     <= 1'b1;
          slotWrite[n]   <= reqWrite[n];
          slotAddress[n] <= reqAddress[n];
          slotData[n]    <= reqData[n];
        end
      end

      if (grantNow) begin
        curGrant  <= grantSel;
        lastGrant <= grantSel;
        curWrite  <= slotWrite[grantSel];
        timer     <= TIMER_LOAD;
        if (slotWrite[grantSel]) begin
          oWriteAddress <= slotAddress[grantSel];
          oWriteData    <= slotData[grantSel];
          oWriteValid   <= 1'b1;
        end else begin
          oReadAddress <= slotAddress[grantSel];
          oReadValid   <= 1'b1;
        end
      end else if (state == ISSUE && !complete) begin
        timer <= timer - 16'd1;
      end

      // Completion lands in an IDLE cycle; the other slot may be granted there.
      if (complete) begin
        oWriteValid           <= 1'b0;
        oReadValid            <= 1'b0;
        pending[curGrant]     <= 1'b0;
        doneReg[curGrant]     <= 1'b1;
        errorReg[curGrant]    <= timedOut;
        readDataReg[curGrant] <= timedOut ? ERROR_DATA : (curWrite ? 32'd0 : iReadData);
        if (timedOut && oErrorCount != 8'hFF) begin
          oErrorCount <= oErrorCount + 8'd1;
        end
      end
    end
  end

  assign oReq0Ready    = ~pending[0];
  assign oReq1Ready    = ~pending[1];
  assign oReq0Done     = doneReg[0];
  assign oReq1Done     = doneReg[1];
  assign oReq0Error    = errorReg[0];
  assign oReq1Error    = errorReg[1];
  assign oReq0ReadData = readDataReg[0];
  assign oReq1ReadData = readDataReg[1];
  assign oBusy         = (state == ISSUE);

endmodule
